// File: rtl/delay_line_cfg.sv
// rtl/delay_line_cfg.sv - runtime-configurable multi-channel valid-tracked delay line
// Optional macro DELAY_LINE_DATA_RESET_EN adds a reset to the data registers.
module delay_line_cfg #(
  parameter int DATA      = 32,
  parameter int CH        = 1,
  parameter int MAX_DEPTH = 8,
  parameter int DEF_DEPTH = 4,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic [CH*DATA-1:0] data_in,
  input  logic               valid_in,
  input  logic               cfg_load,
  input  logic [DW-1:0]      cfg_depth,
  output logic [CH*DATA-1:0] data_out,
  output logic               valid_out,
  output logic [DW-1:0]      depth_cur,
  output logic [DW-1:0]      inflight,
  output logic               busy,
  output logic               cfg_err
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEF_D = DW'(DEF_DEPTH);

  logic [MAX_DEPTH:1] v;
  logic [CH*DATA-1:0] s [1:MAX_DEPTH];

  logic               cfg_ok;
  logic               shift;
  logic               tap_v;
  logic [CH*DATA-1:0] tap_data;
  logic               inc;
  logic               dec;

  // A new depth is only taken when nothing can be lost, or the line is being flushed anyway.
  assign cfg_ok = cfg_load && (cfg_depth <= MAX_D) && ((inflight == '0) || flush);
  assign shift  = en && !flush && !cfg_ok;

  always_comb begin
    tap_v    = 1'b0;
    tap_data = data_in;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (depth_cur == DW'(k)) begin
        tap_v    = v[k];
        tap_data = s[k];
      end
    end
  end

  assign inc = valid_in && (depth_cur != '0);
  assign dec = tap_v;

  assign data_out  = tap_data;
  assign valid_out = !flush && !cfg_ok && en && ((depth_cur == '0) ? valid_in : tap_v);
  assign busy      = (inflight != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v         <= '0;
      depth_cur <= DEF_D;
      inflight  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        depth_cur <= cfg_depth;
        v         <= '0;
        inflight  <= '0;
      end else if (flush) begin
        v        <= '0;
        inflight <= '0;
      end else if (en) begin
        v[1] <= valid_in;
        for (int k = 2; k <= MAX_DEPTH; k++) begin
          v[k] <= v[k-1];
        end
        case ({inc, dec})
          2'b10:   inflight <= inflight + DW'(1);
          2'b01:   inflight <= inflight - DW'(1);
          default: inflight <= inflight;
        endcase
      end
    end
  end

`ifdef DELAY_LINE_DATA_RESET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        s[k] <= '0;
      end
    end else if (shift) begin
      s[1] <= data_in;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        s[k] <= s[k-1];
      end
    end
  end
`else
  // No reset on the data path so the chain can map onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (shift) begin
      s[1] <= data_in;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        s[k] <= s[k-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_delay_line_cfg.sv
// tb/tb_delay_line_cfg.sv - directed self-checking bench for delay_line_cfg
// Two 16-bit channels, MAX_DEPTH=8, DEF_DEPTH=4.
module tb_delay_line_cfg;

  localparam int DATA = 16;
  localparam int CH   = 2;
  localparam int DW   = 4;

  logic               clk;
  logic               reset;
  logic               en;
  logic               flush;
  logic [CH*DATA-1:0] data_in;
  logic               valid_in;
  logic               cfg_load;
  logic [DW-1:0]      cfg_depth;
  logic [CH*DATA-1:0] data_out;
  logic               valid_out;
  logic [DW-1:0]      depth_cur;
  logic [DW-1:0]      inflight;
  logic               busy;
  logic               cfg_err;

  int n_cmp;
  int n_err;
  int nvo;

  delay_line_cfg #(.DATA(DATA), .CH(CH), .MAX_DEPTH(8), .DEF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .data_in(data_in), .valid_in(valid_in),
    .cfg_load(cfg_load), .cfg_depth(cfg_depth),
    .data_out(data_out), .valid_out(valid_out),
    .depth_cur(depth_cur), .inflight(inflight),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [15:0] x);
    return {x ^ 16'hFFFF, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic vi, input logic [31:0] d,
                       input logic fl, input logic cl, input logic [DW-1:0] cd);
    en        = e;
    valid_in  = vi;
    data_in   = d;
    flush     = fl;
    cfg_load  = cl;
    cfg_depth = cd;
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, pk(16'hDEAD), 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    en = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;
    cfg_load = 1'b0; cfg_depth = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    idle();
    check("rst_depth", 32'(depth_cur), 32'd4);
    check("rst_vo", 32'(valid_out), 32'd0);
    check("rst_inf", 32'(inflight), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
`ifdef DELAY_LINE_DATA_RESET_EN
    check("rst_data", data_out, 32'd0);
`endif

    // continuous stream at default depth 4
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, pk(16'(i + 1)), 1'b0, 1'b0, 4'd0);
      check("t1_vo", 32'(valid_out), 32'(i >= 4));
      if (i >= 4) check("t1_do", data_out, pk(16'(i - 3)));
      check("t1_inf", 32'(inflight), (i < 4) ? 32'(i) : 32'd4);
      adv();
    end
    for (int i = 8; i < 12; i++) begin
      idle();
      check("t1_dr_vo", 32'(valid_out), 32'd1);
      check("t1_dr_do", data_out, pk(16'(i - 3)));
      check("t1_dr_inf", 32'(inflight), 32'(12 - i));
      adv();
    end
    idle();
    check("t1_end_vo", 32'(valid_out), 32'd0);
    check("t1_end_busy", 32'(busy), 32'd0);

    // stall: en=0 cycles do not count toward latency
    drive(1'b1, 1'b1, pk(16'hA1), 1'b0, 1'b0, 4'd0); adv();
    drive(1'b1, 1'b1, pk(16'hA2), 1'b0, 1'b0, 4'd0); adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, pk(16'hBAD0), 1'b0, 1'b0, 4'd0);
      check("t2_stall_vo", 32'(valid_out), 32'd0);
      check("t2_stall_inf", 32'(inflight), 32'd2);
      adv();
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      check("t2_wait_vo", 32'(valid_out), 32'd0);
      adv();
    end
    idle();
    check("t2_a1_vo", 32'(valid_out), 32'd1);
    check("t2_a1_do", data_out, pk(16'hA1));
    adv();
    idle();
    check("t2_a2_vo", 32'(valid_out), 32'd1);
    check("t2_a2_do", data_out, pk(16'hA2));
    check("t2_a2_inf", 32'(inflight), 32'd1);
    adv();
    idle();
    check("t2_end_vo", 32'(valid_out), 32'd0);
    check("t2_end_inf", 32'(inflight), 32'd0);

    // load rejected while busy, then accepted when empty
    drive(1'b1, 1'b1, pk(16'hB1), 1'b0, 1'b0, 4'd0); adv();
    drive(1'b1, 1'b1, pk(16'hB2), 1'b0, 1'b0, 4'd0); adv();
    drive(1'b1, 1'b0, pk(16'h0000), 1'b0, 1'b1, 4'd2);
    check("t3_rej_inf", 32'(inflight), 32'd2);
    adv();
    idle();
    check("t3_err", 32'(cfg_err), 32'd1);
    check("t3_depth_kept", 32'(depth_cur), 32'd4);
    adv();
    idle();
    check("t3_err_clr", 32'(cfg_err), 32'd0);
    check("t3_b1_vo", 32'(valid_out), 32'd1);
    check("t3_b1_do", data_out, pk(16'hB1));
    adv();
    idle();
    check("t3_b2_do", data_out, pk(16'hB2));
    adv();
    drive(1'b1, 1'b1, pk(16'hBEEF), 1'b0, 1'b1, 4'd2);
    check("t3_acc_inf", 32'(inflight), 32'd0);
    adv();
    drive(1'b1, 1'b1, pk(16'hC1), 1'b0, 1'b0, 4'd0);
    check("t3_depth2", 32'(depth_cur), 32'd2);
    check("t3_acc_noerr", 32'(cfg_err), 32'd0);
    check("t3_c1_vo0", 32'(valid_out), 32'd0);
    adv();
    idle();
    check("t3_junk_vo", 32'(valid_out), 32'd0);
    adv();
    idle();
    check("t3_c1_vo", 32'(valid_out), 32'd1);
    check("t3_c1_do", data_out, pk(16'hC1));
    adv();

    // depth 0 pass-through and out-of-range load
    drive(1'b1, 1'b1, pk(16'h0077), 1'b0, 1'b1, 4'd0);
    adv();
    drive(1'b1, 1'b1, pk(16'h0055), 1'b0, 1'b0, 4'd0);
    check("t4_depth0", 32'(depth_cur), 32'd0);
    check("t4_pt_vo", 32'(valid_out), 32'd1);
    check("t4_pt_do", data_out, pk(16'h0055));
    adv();
    drive(1'b0, 1'b1, pk(16'h0066), 1'b0, 1'b0, 4'd0);
    check("t4_pt_en0_vo", 32'(valid_out), 32'd0);
    check("t4_pt_en0_do", data_out, pk(16'h0066));
    check("t4_pt_inf", 32'(inflight), 32'd0);
    adv();
    drive(1'b1, 1'b1, pk(16'h0044), 1'b0, 1'b1, 4'd0);
    check("t4_load_vo", 32'(valid_out), 32'd0);
    adv();
    drive(1'b1, 1'b0, pk(16'h0000), 1'b0, 1'b1, 4'd9);
    adv();
    drive(1'b1, 1'b1, pk(16'h0033), 1'b0, 1'b0, 4'd0);
    check("t4_oor_err", 32'(cfg_err), 32'd1);
    check("t4_oor_depth", 32'(depth_cur), 32'd0);
    check("t4_oor_pt_do", data_out, pk(16'h0033));
    adv();

    // flush combined with a load to depth 3
    drive(1'b1, 1'b0, pk(16'h0000), 1'b0, 1'b1, 4'd8);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, pk(16'(16'hD1 + i)), 1'b0, 1'b0, 4'd0);
      adv();
    end
    drive(1'b1, 1'b1, pk(16'h0099), 1'b1, 1'b1, 4'd3);
    check("t5_pre_inf", 32'(inflight), 32'd3);
    check("t5_flush_vo", 32'(valid_out), 32'd0);
    adv();
    drive(1'b1, 1'b1, pk(16'hE1), 1'b0, 1'b0, 4'd0);
    check("t5_depth3", 32'(depth_cur), 32'd3);
    check("t5_inf0", 32'(inflight), 32'd0);
    check("t5_busy0", 32'(busy), 32'd0);
    check("t5_noerr", 32'(cfg_err), 32'd0);
    adv();
    nvo = 0;
    for (int i = 0; i < 2; i++) begin
      idle();
      nvo += int'(valid_out);
      adv();
    end
    check("t5_gap_vo", 32'(nvo), 32'd0);
    idle();
    check("t5_e1_vo", 32'(valid_out), 32'd1);
    check("t5_e1_do", data_out, pk(16'hE1));
    adv();

    // flush alone, including on the cycle an item reaches the tap
    drive(1'b1, 1'b1, pk(16'hF1), 1'b0, 1'b0, 4'd0); adv();
    drive(1'b1, 1'b1, pk(16'hF2), 1'b0, 1'b0, 4'd0); adv();
    idle(); adv();
    drive(1'b1, 1'b0, pk(16'h0000), 1'b1, 1'b0, 4'd0);
    check("t5b_flush_vo", 32'(valid_out), 32'd0);
    adv();
    idle();
    check("t5b_inf", 32'(inflight), 32'd0);
    nvo = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      nvo += int'(valid_out);
      adv();
    end
    check("t5b_after_vo", 32'(nvo), 32'd0);

    // grow depth 2 -> 6: stale items in stages 3..6 must not emerge
    drive(1'b1, 1'b0, pk(16'h0000), 1'b0, 1'b1, 4'd2);
    adv();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, pk(16'(16'h0A0 + i)), 1'b0, 1'b0, 4'd0);
      adv();
    end
    idle(); adv();
    idle(); adv();
    drive(1'b1, 1'b0, pk(16'h0000), 1'b0, 1'b1, 4'd6);
    check("t6_pre_inf", 32'(inflight), 32'd0);
    adv();
    nvo = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      nvo += int'(valid_out);
      adv();
    end
    check("t6_stale_vo", 32'(nvo), 32'd0);
    check("t6_depth6", 32'(depth_cur), 32'd6);

    // asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, pk(16'(16'h0C1 + i)), 1'b0, 1'b0, 4'd0);
      if (i < 6) adv();
    end
    check("t6_h1_vo", 32'(valid_out), 32'd1);
    check("t6_h1_do", data_out, pk(16'h0C1));
    #2 reset = 1'b1;
    #1;
    check("t6_rst_vo", 32'(valid_out), 32'd0);
    check("t6_rst_depth", 32'(depth_cur), 32'd4);
    check("t6_rst_inf", 32'(inflight), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
`ifdef DELAY_LINE_DATA_RESET_EN
    check("t6_rst_data", data_out, 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    check("t6_post_vo", 32'(valid_out), 32'd0);
    check("t6_post_depth", 32'(depth_cur), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
